mem_read_burst_scheduler: RTL and testbench

- Sequences AXI4 read bursts for the memory read test kernel.
- Walks a strided address window: base `ctrl_addr_offset`, step `addr_incr`, limit `mem_max_addr`.
- Bounds the number of outstanding bursts and sinks all returned read data.
- Reports bandwidth counters to the host-visible register layer.
- Sits between kernel control (`ap_start`/`ap_done`) and the m_axi AR/R channels.

---
 rtl/mem_read_sched_pkg.sv | 20 ++
 rtl/mem_read_sched_ts_fifo.sv | 38 +++
 rtl/mem_read_burst_scheduler.sv | 175 +++++++++++++++++
 tb/tb_mem_read_burst_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_sched_pkg.sv
// Shared types and sizing helpers for the memory-read burst scheduler.
package mem_read_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OFFSET_W = 33;
    localparam int CYCLES_W = 64;
    localparam int COUNT_W  = 32;

    // Wide enough to hold the value C_MAX_OUTSTANDING itself, not just max-1.
    function automatic int outstanding_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage

// File: rtl/mem_read_sched_ts_fifo.sv
// Register-based timestamp FIFO for AR-to-rlast latency measurement.
// Built only when MEM_READ_BURST_SCHEDULER_LATENCY_EN is defined; DEPTH must be a power of 2.
module mem_read_sched_ts_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage is deliberately left out of reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/mem_read_burst_scheduler.sv
// AXI4 read-burst sequencer: walks a strided window, bounds outstanding bursts, sinks data, counts stats.
// Optional AR-to-rlast latency tracking is enabled by MEM_READ_BURST_SCHEDULER_LATENCY_EN.
module mem_read_burst_scheduler
    import mem_read_sched_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 256,
    parameter int C_MAX_OUTSTANDING  = 16,
    parameter int C_BURST_LEN        = 64
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          busy,
    input  logic [63:0]                   ctrl_addr_offset,
    input  logic [31:0]                   addr_incr,
    input  logic [31:0]                   mem_max_addr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic [CYCLES_W-1:0]           stat_cycles,
    output logic [COUNT_W-1:0]            stat_bursts,
    output logic [COUNT_W-1:0]            stat_beats,
    output logic [COUNT_W-1:0]            stat_lat_max
);
    localparam int               OUT_W   = outstanding_width(C_MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(C_MAX_OUTSTANDING);

    state_t                        state, state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0] base;
    logic [31:0]                   incr, limit, offset;
    logic [OFFSET_W-1:0]           offset_sum;
    logic [OUT_W-1:0]              outstanding, outstanding_next;
    logic                          arvalid, arvalid_next, rready;
    logic                          start, ar_hs, r_hs, last_hs, walk_end;
    logic                          rdata_unused;

    assign rdata_unused = ^m_axi_rdata;

    assign start   = (state == IDLE) && ap_start;
    assign ar_hs   = arvalid && m_axi_arready;
    assign r_hs    = m_axi_rvalid && rready;
    assign last_hs = r_hs && m_axi_rlast;

    // A carry into bit 32 ends the walk just like reaching the limit does.
    assign offset_sum = {1'b0, offset} + {1'b0, incr};
    assign walk_end   = (incr == '0) || (offset_sum >= {1'b0, limit}) || offset_sum[32];

    // An rlast with nothing outstanding is a protocol error; the count is held at 0.
    always_comb begin
        outstanding_next = outstanding;
        if (ar_hs && !last_hs)
            outstanding_next = outstanding + OUT_W'(1);
        else if (last_hs && !ar_hs && outstanding != '0)
            outstanding_next = outstanding - OUT_W'(1);
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next   = state;
        arvalid_next = arvalid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next   = (mem_max_addr == '0) ? DONE : ISSUE;
                    arvalid_next = (mem_max_addr != '0);
                end
            end
            ISSUE: begin
                if (ar_hs && walk_end) begin
                    state_next   = DRAIN;
                    arvalid_next = 1'b0;
                end else if (!arvalid || ar_hs) begin
                    arvalid_next = (outstanding_next < OUT_MAX);
                end
            end
            DRAIN: begin
                if (outstanding_next == '0) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            state   <= state_next;
            arvalid <= arvalid_next;
            rready  <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            base        <= '0;
            incr        <= '0;
            limit       <= '0;
            offset      <= '0;
            outstanding <= '0;
            stat_cycles <= '0;
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else if (start) begin
            base        <= ctrl_addr_offset[C_M_AXI_ADDR_WIDTH-1:0];
            incr        <= addr_incr;
            limit       <= mem_max_addr;
            offset      <= '0;
            outstanding <= '0;
            stat_cycles <= '0;
            stat_bursts <= '0;
            stat_beats  <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (ar_hs && !walk_end) offset      <= offset_sum[31:0];
            if (busy)               stat_cycles <= stat_cycles + CYCLES_W'(1);
            if (ar_hs)              stat_bursts <= stat_bursts + COUNT_W'(1);
            if (r_hs)               stat_beats  <= stat_beats + COUNT_W'(1);
        end
    end

`ifdef MEM_READ_BURST_SCHEDULER_LATENCY_EN
    logic [COUNT_W-1:0] ts_head, latency, lat_max;
    logic               ts_pop;

    assign ts_pop  = last_hs && (outstanding != '0);
    assign latency = stat_cycles[COUNT_W-1:0] - ts_head;

    mem_read_sched_ts_fifo #(
        .DEPTH (C_MAX_OUTSTANDING),
        .WIDTH (COUNT_W)
    ) u_ts_fifo (
        .clk       (aclk),
        .rst       (areset),
        .clr       (start),
        .push      (ar_hs),
        .push_data (stat_cycles[COUNT_W-1:0]),
        .pop       (ts_pop),
        .pop_data  (ts_head)
    );

    always_ff @(posedge aclk) begin
        if (areset || start)
            lat_max <= '0;
        else if (ts_pop && latency > lat_max)
            lat_max <= latency;
    end

    assign stat_lat_max = lat_max;
`else
    assign stat_lat_max = '0;
`endif

    assign busy          = (state != IDLE);
    assign ap_done       = (state == DONE);
    assign m_axi_arvalid = arvalid;
    assign m_axi_rready  = rready;
    assign m_axi_araddr  = base + C_M_AXI_ADDR_WIDTH'(offset);
    assign m_axi_arlen   = 8'(C_BURST_LEN - 1);

endmodule

// File: tb/tb_mem_read_burst_scheduler.sv
// Self-checking bench: vector table of address windows plus hand sequences for backpressure,
// simultaneous AR/rlast, ignored start and mid-run reset. AR addresses are scoreboarded.
module tb_mem_read_burst_scheduler;
    localparam int AW   = 64;
    localparam int DW   = 256;
    localparam int MAXO = 16;
    localparam int BL   = 64;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ap_start;
    logic          ap_done;
    logic          busy;
    logic [63:0]   ctrl_addr_offset;
    logic [31:0]   addr_incr;
    logic [31:0]   mem_max_addr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic          m_axi_rlast;
    logic [63:0]   stat_cycles;
    logic [31:0]   stat_bursts;
    logic [31:0]   stat_beats;
    logic [31:0]   stat_lat_max;

    always #5 aclk = ~aclk;

    mem_read_burst_scheduler #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_MAX_OUTSTANDING  (MAXO),
        .C_BURST_LEN        (BL)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .busy             (busy),
        .ctrl_addr_offset (ctrl_addr_offset),
        .addr_incr        (addr_incr),
        .mem_max_addr     (mem_max_addr),
        .m_axi_arvalid    (m_axi_arvalid),
        .m_axi_arready    (m_axi_arready),
        .m_axi_araddr     (m_axi_araddr),
        .m_axi_arlen      (m_axi_arlen),
        .m_axi_rvalid     (m_axi_rvalid),
        .m_axi_rready     (m_axi_rready),
        .m_axi_rdata      (m_axi_rdata),
        .m_axi_rlast      (m_axi_rlast),
        .stat_cycles      (stat_cycles),
        .stat_bursts      (stat_bursts),
        .stat_beats       (stat_beats),
        .stat_lat_max     (stat_lat_max)
    );

    typedef struct {
        logic [63:0] base;
        logic [31:0] incr;
        logic [31:0] max;
        bit          ar_rand;
        int          exp_bursts;
        logic [63:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;

    // Bench-side models: memory return queue, AR scoreboard and observed counts.
    int          cyc = 0;
    int          mem_lat = 0;
    int          beat_limit = 0;
    int          ar_limit = 0;
    bit          ar_rand = 1'b0;
    int          pend_ready[$];
    int          ar_ts[$];
    int          beat = 0;
    logic [63:0] exp_addr_q[$];
    logic [63:0] last_addr;
    int          ar_cnt, beat_cnt, done_cnt, busy_cycles, lat_max_model;
    bit          both_seen;
    bit          hold_pending = 1'b0;
    logic [63:0] hold_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : (ar_cnt < ar_limit);
        m_axi_rvalid  = (pend_ready.size() != 0) && (cyc >= pend_ready[0]) && (beat_cnt < beat_limit);
        m_axi_rlast   = m_axi_rvalid && (beat == BL - 1);
        for (int k = 0; k < DW / 32; k++) m_axi_rdata[32*k +: 32] = $urandom();
    endtask

    // Observe the upcoming edge at negedge, then update the drivers #1 after it.
    task automatic tick();
        bit ar_hs, r_hs, r_last;
        int l;
        @(negedge aclk);
        ar_hs  = m_axi_arvalid && m_axi_arready;
        r_hs   = m_axi_rvalid && m_axi_rready;
        r_last = r_hs && m_axi_rlast;
        if (hold_pending) begin
            check("arvalid_hold", m_axi_arvalid, 1);
            check("araddr_hold", m_axi_araddr, hold_addr);
        end
        hold_pending = m_axi_arvalid && !m_axi_arready && !areset;
        hold_addr    = m_axi_araddr;
        if (busy)    busy_cycles++;
        if (ap_done) done_cnt++;
        both_seen = ar_hs && r_last;
        if (ar_hs) begin
            ar_cnt++;
            last_addr = m_axi_araddr;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ar_unexpected: got 0x%0h expected no AR", m_axi_araddr);
            end else begin
                check("ar_addr", m_axi_araddr, exp_addr_q.pop_front());
            end
            pend_ready.push_back(cyc + mem_lat);
            ar_ts.push_back(cyc);
        end
        if (r_hs) beat_cnt++;
        if (r_last && ar_ts.size() != 0) begin
            l = cyc - ar_ts.pop_front();
            if (l > lat_max_model) lat_max_model = l;
        end
        @(posedge aclk);
        #1;
        cyc++;
        if (r_hs && pend_ready.size() != 0) begin
            beat++;
            if (beat == BL) begin
                beat = 0;
                void'(pend_ready.pop_front());
            end
        end
        drive();
    endtask

    task automatic push_walk(input logic [63:0] base, input logic [31:0] incr, input logic [31:0] max);
        logic [32:0] off, nxt;
        off = '0;
        if (max == 0) return;
        for (int n = 0; n < 100000; n++) begin
            exp_addr_q.push_back(base + 64'(off[31:0]));
            nxt = off + {1'b0, incr};
            if (incr == 0 || nxt >= {1'b0, max} || nxt[32]) break;
            off = nxt;
        end
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] incr, input logic [31:0] max);
        ar_cnt = 0; beat_cnt = 0; done_cnt = 0; busy_cycles = 0; lat_max_model = 0;
        exp_addr_q.delete();
        push_walk(base, incr, max);
        ctrl_addr_offset = base;
        addr_incr        = incr;
        mem_max_addr     = max;
        ap_start         = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    task automatic reset_dut();
        areset     = 1'b1;
        beat_limit = 0;
        ar_limit   = 0;
        ar_rand    = 1'b0;
        tick();
        tick();
        pend_ready.delete();
        ar_ts.delete();
        exp_addr_q.delete();
        beat = 0;
        hold_pending = 1'b0;
        areset = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        ar_limit   = 1 << 30;
        beat_limit = 1 << 30;
        mem_lat    = 20;
        ar_rand    = v.ar_rand;
        start_job(v.base, v.incr, v.max);
        check($sformatf("v%0d_arvalid_after_start", idx), m_axi_arvalid, (v.exp_bursts != 0));
        for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
        tick();
        tick();
        check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d_ar_count", idx), ar_cnt, v.exp_bursts);
        check($sformatf("v%0d_stat_bursts", idx), stat_bursts, v.exp_bursts);
        check($sformatf("v%0d_stat_beats", idx), stat_beats, v.exp_bursts * BL);
        check($sformatf("v%0d_beats_seen", idx), beat_cnt, v.exp_bursts * BL);
        check($sformatf("v%0d_busy_after", idx), busy, 0);
        check($sformatf("v%0d_stat_cycles", idx), stat_cycles, busy_cycles);
        check($sformatf("v%0d_sb_empty", idx), exp_addr_q.size(), 0);
        if (v.exp_bursts != 0) check($sformatf("v%0d_last_addr", idx), last_addr, v.exp_last);
`ifdef MEM_READ_BURST_SCHEDULER_LATENCY_EN
        check($sformatf("v%0d_lat_max", idx), stat_lat_max, lat_max_model);
`else
        check($sformatf("v%0d_lat_max", idx), stat_lat_max, 0);
`endif
        ar_rand = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h1000, 32'h800, 32'h2000, 1'b0, 4, 64'h2800};
        vecs[1] = '{64'h4000, 32'h0, 32'h100, 1'b0, 1, 64'h4000};
        vecs[2] = '{64'h0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 2, 64'h8000_0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_F000, 32'h1000, 32'h3000, 1'b1, 3, 64'h1000};
        vecs[4] = '{64'h100, 32'h40, 32'h41, 1'b1, 2, 64'h140};
        vecs[5] = '{64'h0, 32'h100, 32'h2000, 1'b1, 32, 64'h1F00};
        vecs[6] = '{64'h1_0000_0000, 32'h40, 32'h40, 1'b0, 1, 64'h1_0000_0000};

        areset = 1'b1; ap_start = 1'b0;
        ctrl_addr_offset = '0; addr_incr = '0; mem_max_addr = '0;
        ar_cnt = 0; beat_cnt = 0; done_cnt = 0; busy_cycles = 0; lat_max_model = 0;
        drive();
        repeat (3) tick();
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_busy", busy, 0);
        check("rst_ap_done", ap_done, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_arlen", m_axi_arlen, BL - 1);
        check("rst_stat_cycles", stat_cycles, 0);
        check("rst_stat_bursts", stat_bursts, 0);
        check("rst_stat_beats", stat_beats, 0);
        check("rst_stat_lat_max", stat_lat_max, 0);
        areset = 1'b0;
        tick();
        check("rready_after_reset", m_axi_rready, 1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Empty window: straight to DONE, one-cycle pulse, no AR.
        start_job(64'h1000, 32'h100, 32'h0);
        check("max0_ap_done", ap_done, 1);
        check("max0_busy", busy, 1);
        check("max0_arvalid", m_axi_arvalid, 0);
        tick();
        check("max0_ap_done_drop", ap_done, 0);
        check("max0_busy_drop", busy, 0);
        repeat (3) tick();
        check("max0_ar_count", ar_cnt, 0);
        check("max0_stat_bursts", stat_bursts, 0);
        check("max0_stat_beats", stat_beats, 0);
        check("max0_stat_cycles", stat_cycles, busy_cycles);

        // Outstanding limit with no data returning, then release exactly one burst.
        mem_lat = 0; ar_limit = 1 << 30; beat_limit = 0;
        start_job(64'h0, 32'h100, 32'h0010_0000);
        repeat (40) tick();
        check("bp_ar_count", ar_cnt, MAXO);
        check("bp_stat_bursts", stat_bursts, MAXO);
        check("bp_arvalid_low", m_axi_arvalid, 0);
        beat_limit = BL;
        repeat (100) tick();
        check("bp_release_ar_count", ar_cnt, MAXO + 1);
        check("bp_release_beats", beat_cnt, BL);
        check("bp_release_stat_beats", stat_beats, BL);
        check("bp_release_arvalid_low", m_axi_arvalid, 0);
        reset_dut();

        // AR handshake and rlast on the same edge at 15 outstanding.
        mem_lat = 0; ar_limit = MAXO - 1; beat_limit = 0;
        start_job(64'h0, 32'h100, 32'h0010_0000);
        repeat (40) tick();
        check("sim_ar_count_15", ar_cnt, MAXO - 1);
        check("sim_arvalid_pending", m_axi_arvalid, 1);
        beat_limit = BL - 1;
        repeat (80) tick();
        check("sim_beats_63", beat_cnt, BL - 1);
        ar_limit = MAXO; beat_limit = BL;
        tick();
        tick();
        check("sim_both_same_edge", both_seen, 1);
        check("sim_arvalid_after", m_axi_arvalid, 1);
        check("sim_stat_bursts", stat_bursts, MAXO);
        repeat (3) tick();
        check("sim_arvalid_held", m_axi_arvalid, 1);
        check("sim_no_extra_ar", ar_cnt, MAXO);

        // A start pulse while running must not clear anything.
        ctrl_addr_offset = 64'hABC0_0000; addr_incr = 32'h10; mem_max_addr = 32'h20;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        check("ign_start_bursts", stat_bursts, MAXO);
        check("ign_start_beats", stat_beats, BL);
        check("ign_start_busy", busy, 1);
        check("ign_start_cycles", stat_cycles, busy_cycles);
        reset_dut();

        // Reset with three bursts outstanding, then a clean run.
        mem_lat = 0; ar_limit = 3; beat_limit = 0;
        start_job(64'h2000, 32'h40, 32'h10000);
        repeat (10) tick();
        check("mid_ar_count", ar_cnt, 3);
        check("mid_arvalid_before", m_axi_arvalid, 1);
        areset = 1'b1;
        tick();
        check("mid_arvalid", m_axi_arvalid, 0);
        check("mid_busy", busy, 0);
        check("mid_ap_done", ap_done, 0);
        check("mid_stat_cycles", stat_cycles, 0);
        check("mid_stat_bursts", stat_bursts, 0);
        check("mid_stat_beats", stat_beats, 0);
        check("mid_stat_lat_max", stat_lat_max, 0);
        check("mid_rready", m_axi_rready, 0);
        reset_dut();
        run_vec(10, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
